// File: rtl/mips_mem_arbiter.sv
// ============================================================================
// Module   : mips_mem_arbiter
// Brief    : Round-robin arbiter sharing one single-port synchronous word
//            memory between instruction fetch (port 0) and data (port 1).
//            Optional ARB_PERF_EN macro adds saturating grant/conflict counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_mem_arbiter #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [ADDR_W-1:0] r0_addr,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [31:0]       perf_grant0,
    output logic [31:0]       perf_grant1,
    output logic [31:0]       perf_conflict
);

    logic gnt0;
    logic gnt1;
    logic last_gnt_q, last_gnt_d;
    logic resp_pend_q, resp_pend_d;
    logic resp_id_q, resp_id_d;

    // On conflict the port that did not win last time is served.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (r0_valid && (!r1_valid || last_gnt_q)) begin
                gnt0 = 1'b1;
            end else if (r1_valid) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign r0_ready = gnt0;
    assign r1_ready = gnt1;

    always_comb begin
        mem_en    = gnt0 | gnt1;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt0) begin
            mem_addr = r0_addr;
        end else if (gnt1) begin
            mem_we    = r1_we;
            mem_addr  = r1_addr;
            mem_wdata = r1_wdata;
        end
    end

    always_comb begin
        last_gnt_d  = last_gnt_q;
        resp_pend_d = 1'b0;
        resp_id_d   = resp_id_q;
        if (reset) begin
            last_gnt_d = 1'b1;
            resp_id_d  = 1'b0;
        end else if (gnt0) begin
            last_gnt_d  = 1'b0;
            resp_pend_d = 1'b1;
            resp_id_d   = 1'b0;
        end else if (gnt1) begin
            last_gnt_d  = 1'b1;
            resp_pend_d = !r1_we;
            resp_id_d   = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        last_gnt_q  <= last_gnt_d;
        resp_pend_q <= resp_pend_d;
        resp_id_q   <= resp_id_d;
    end

    // A response pending across a reset edge is dropped.
    assign r0_rvalid = resp_pend_q && !resp_id_q && !reset;
    assign r1_rvalid = resp_pend_q &&  resp_id_q && !reset;
    assign r0_rdata  = r0_rvalid ? mem_rdata : '0;
    assign r1_rdata  = r1_rvalid ? mem_rdata : '0;

`ifdef ARB_PERF_EN
    logic [31:0] grant0_q, grant0_d;
    logic [31:0] grant1_q, grant1_d;
    logic [31:0] conflict_q, conflict_d;

    always_comb begin
        grant0_d   = grant0_q;
        grant1_d   = grant1_q;
        conflict_d = conflict_q;
        if (reset) begin
            grant0_d   = '0;
            grant1_d   = '0;
            conflict_d = '0;
        end else begin
            if (gnt0 && grant0_q != 32'hFFFF_FFFF) grant0_d = grant0_q + 32'd1;
            if (gnt1 && grant1_q != 32'hFFFF_FFFF) grant1_d = grant1_q + 32'd1;
            if (r0_valid && r1_valid && conflict_q != 32'hFFFF_FFFF) begin
                conflict_d = conflict_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        grant0_q   <= grant0_d;
        grant1_q   <= grant1_d;
        conflict_q <= conflict_d;
    end

    assign perf_grant0   = grant0_q;
    assign perf_grant1   = grant1_q;
    assign perf_conflict = conflict_q;
`else
    assign perf_grant0   = 32'd0;
    assign perf_grant1   = 32'd0;
    assign perf_conflict = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mips_mem_arbiter.sv
// ============================================================================
// Module   : tb_mips_mem_arbiter
// Brief    : Scoreboard bench for mips_mem_arbiter with a behavioural memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        r0_valid = 1'b0, r0_ready;
    logic [6:0]  r0_addr = '0;
    logic        r0_rvalid;
    logic [31:0] r0_rdata;
    logic        r1_valid = 1'b0, r1_ready, r1_we = 1'b0;
    logic [6:0]  r1_addr = '0;
    logic [31:0] r1_wdata = '0;
    logic        r1_rvalid;
    logic [31:0] r1_rdata;
    logic        mem_en, mem_we;
    logic [6:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [31:0] perf_grant0, perf_grant1, perf_conflict;

    mips_mem_arbiter #(.ADDR_W(7), .DATA_W(32)) dut (
        .clock(clock), .reset(reset),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_addr(r0_addr),
        .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we),
        .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .perf_grant0(perf_grant0), .perf_grant1(perf_grant1),
        .perf_conflict(perf_conflict)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Memory contents: address 5 holds 0xDEADBEEF, others 0xA0000000 | addr.
    function automatic logic [31:0] init_word(input logic [6:0] a);
        return (a == 7'd5) ? 32'hDEAD_BEEF : (32'hA000_0000 | {25'd0, a});
    endfunction

    logic [31:0]  mem [128];
    logic [127:0] wr_mask = '0;
    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr]     <= mem_wdata;
                wr_mask[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= wr_mask[mem_addr] ? mem[mem_addr] : init_word(mem_addr);
            end
        end
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    typedef struct {
        logic        id;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t sb[$];

    // Monitor: retire responses in order, each due exactly one cycle after its grant.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #2;
            while (sb.size() > 0 && sb[0].due < cyc) begin
                e = sb.pop_front();
                check("missing_rvalid", 32'd0, 32'd1);
            end
            if (r0_rvalid || r1_rvalid) begin
                check("single_rvalid", {31'd0, r0_rvalid & r1_rvalid}, 32'd0);
                if (sb.size() == 0) begin
                    check("unexpected_rvalid", {30'd0, r1_rvalid, r0_rvalid}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("resp_id", {31'd0, r1_rvalid}, {31'd0, e.id});
                    check("resp_data", e.id ? r1_rdata : r0_rdata, e.data);
                    check("resp_other_zero", e.id ? r0_rdata : r1_rdata, 32'd0);
                    check("resp_cycle", cyc, e.due);
                end
            end
        end
    end

    task automatic step(input string nm,
                        input logic v0, input logic [6:0] a0,
                        input logic v1, input logic we1, input logic [6:0] a1,
                        input logic [31:0] wd,
                        input logic eg0, input logic eg1,
                        input logic [31:0] ed, input logic push);
        logic [6:0] ea;
        @(negedge clock);
        reset = 1'b0;
        r0_valid = v0; r0_addr = a0;
        r1_valid = v1; r1_we = we1; r1_addr = a1; r1_wdata = wd;
        #1;
        ea = eg0 ? a0 : (eg1 ? a1 : 7'd0);
        check({nm, "_ready0"}, {31'd0, r0_ready}, {31'd0, eg0});
        check({nm, "_ready1"}, {31'd0, r1_ready}, {31'd0, eg1});
        check({nm, "_mem_en"}, {31'd0, mem_en}, {31'd0, eg0 | eg1});
        check({nm, "_mem_we"}, {31'd0, mem_we}, {31'd0, eg1 & we1});
        check({nm, "_mem_addr"}, {25'd0, mem_addr}, {25'd0, ea});
        if (eg1 && we1) check({nm, "_mem_wdata"}, mem_wdata, wd);
        if (push && (eg0 || (eg1 && !we1))) begin
            sb.push_back('{id: eg1, data: ed, due: cyc + 1});
        end
    endtask

    task automatic do_reset(input int n, input logic hold_valid);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            reset = 1'b1;
            r0_valid = hold_valid; r1_valid = hold_valid; r1_we = 1'b0;
            #1;
            check("rst_ready0", {31'd0, r0_ready}, 32'd0);
            check("rst_ready1", {31'd0, r1_ready}, 32'd0);
            check("rst_mem_en", {31'd0, mem_en}, 32'd0);
            check("rst_mem_we", {31'd0, mem_we}, 32'd0);
            check("rst_rvalid", {30'd0, r1_rvalid, r0_rvalid}, 32'd0);
        end
    endtask

    task automatic idle(input string nm);
        step(nm, 1'b0, 7'd0, 1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1. Single fetch after a 3-cycle reset.
        do_reset(3, 1'b0);
        step("t1_rd5", 1, 7'd5, 0, 0, 7'd0, 32'd0, 1, 0, 32'hDEAD_BEEF, 1);
        idle("t1_idle");

        // 2. Conflict from reset alternates 0,1,0,1.
        do_reset(1, 1'b0);
        step("t2_c0", 1, 7'd10, 1, 0, 7'd20, 32'd0, 1, 0, 32'hA000_000A, 1);
        step("t2_c1", 1, 7'd10, 1, 0, 7'd20, 32'd0, 0, 1, 32'hA000_0014, 1);
        step("t2_c2", 1, 7'd10, 1, 0, 7'd20, 32'd0, 1, 0, 32'hA000_000A, 1);
        step("t2_c3", 1, 7'd10, 1, 0, 7'd20, 32'd0, 0, 1, 32'hA000_0014, 1);
        idle("t2_idle");

        // 3. Data write followed by a fetch of the same word.
        step("t3_wr9", 0, 7'd0, 1, 1, 7'd9, 32'h1234_5678, 0, 1, 32'd0, 1);
        step("t3_rd9", 1, 7'd9, 0, 0, 7'd0, 32'd0, 1, 0, 32'h1234_5678, 1);
        idle("t3_idle");

        // 4. Data read squashed by reset; first conflict afterwards goes to port 0.
        step("t4_rd3", 0, 7'd0, 1, 0, 7'd3, 32'd0, 0, 1, 32'd0, 0);
        do_reset(1, 1'b1);
        step("t4_conf", 1, 7'd4, 1, 0, 7'd6, 32'd0, 1, 0, 32'hA000_0004, 1);
        idle("t4_idle");

        // 5. Ten conflict cycles from reset.
        do_reset(1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step("t5_conf", 1, 7'd1, 1, 0, 7'd2, 32'd0, (i % 2) == 0, (i % 2) == 1,
                 ((i % 2) == 0) ? 32'hA000_0001 : 32'hA000_0002, 1);
        end
        idle("t5_idle");
`ifdef ARB_PERF_EN
        check("perf_conflict", perf_conflict, 32'd10);
        check("perf_grant0", perf_grant0, 32'd5);
        check("perf_grant1", perf_grant1, 32'd5);
`else
        check("perf_conflict", perf_conflict, 32'd0);
        check("perf_grant0", perf_grant0, 32'd0);
        check("perf_grant1", perf_grant1, 32'd0);
`endif

        // 6. Continuous fetch stream, gap-free responses in address order.
        for (int i = 0; i < 8; i++) begin
            step("t6_stream", 1, 7'd32 + 7'(i), 0, 0, 7'd0, 32'd0, 1, 0,
                 32'hA000_0020 + 32'(i), 1);
        end
        idle("t6_idle0");
        idle("t6_idle1");
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
